// File: rtl/i2c_bus_conditioner.sv
// I2C pad front end: two-flop synchronisers, per-line stability filters, SCL/START/STOP
// event pulses, bus-busy tracking and a stuck-low SCL timeout for the slave protocol FSM.
module i2c_bus_conditioner #(
   parameter int FILT_LEN       = 2,
   parameter int TIMEOUT_CYCLES = 250000,
   parameter int TO_W           = 18
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_f,
   output logic sda_f,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic bus_busy,
   output logic timeout
);

   localparam int FC_W = 4;
   localparam logic [FC_W-1:0] FILT_TC = FC_W'(FILT_LEN - 1);
   localparam logic [TO_W-1:0] TO_TC   = TO_W'(TIMEOUT_CYCLES - 1);

   logic            scl_s1, scl_s2, sda_s1, sda_s2;
   logic            scl_q, sda_q;
   logic [FC_W-1:0] scl_cnt, sda_cnt;
   logic [TO_W-1:0] to_cnt;
   logic            scl_low_busy;
   logic            to_hit;

   // Events come only from the filtered/delayed flop pairs so they cannot glitch.
   assign scl_rise  = scl_f & ~scl_q;
   assign scl_fall  = ~scl_f & scl_q;
   assign start_det = ~sda_f & sda_q & scl_f & scl_q;
   assign stop_det  = sda_f & ~sda_q & scl_f & scl_q;

   assign scl_low_busy = bus_busy & ~scl_f;
   assign to_hit       = scl_low_busy && (to_cnt == TO_TC);

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1   <= 1'b1;
         scl_s2   <= 1'b1;
         sda_s1   <= 1'b1;
         sda_s2   <= 1'b1;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
         scl_cnt  <= '0;
         sda_cnt  <= '0;
         to_cnt   <= '0;
         bus_busy <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         scl_s1 <= scl_in;
         scl_s2 <= scl_s1;
         sda_s1 <= sda_in;
         sda_s2 <= sda_s1;

         // A level must differ from the filtered value for FILT_LEN edges in a row.
         if (scl_s2 != scl_f) begin
            if (scl_cnt == FILT_TC) begin
               scl_f   <= scl_s2;
               scl_cnt <= '0;
            end else begin
               scl_cnt <= scl_cnt + 1'b1;
            end
         end else begin
            scl_cnt <= '0;
         end

         if (sda_s2 != sda_f) begin
            if (sda_cnt == FILT_TC) begin
               sda_f   <= sda_s2;
               sda_cnt <= '0;
            end else begin
               sda_cnt <= sda_cnt + 1'b1;
            end
         end else begin
            sda_cnt <= '0;
         end

         scl_q <= scl_f;
         sda_q <= sda_f;

         // Clearing bus_busy on expiry also stops the counter, so it never re-arms until START.
         if (to_hit) begin
            to_cnt  <= '0;
            timeout <= 1'b1;
         end else if (scl_low_busy) begin
            to_cnt  <= to_cnt + 1'b1;
            timeout <= 1'b0;
         end else begin
            to_cnt  <= '0;
            timeout <= 1'b0;
         end

         if (start_det) begin
            bus_busy <= 1'b1;
         end else if (stop_det || to_hit) begin
            bus_busy <= 1'b0;
         end
      end
   end

endmodule
